// File: rtl/tc_timer_pkg.sv
// Shared constants for tc_timer: register offsets, FSM state codes, mode codes
// and CTRL bit layout.
package tc_timer_pkg;

  // Word offsets, i.e. Addr[3:2]
  localparam logic [1:0] offCtrl   = 2'd0;
  localparam logic [1:0] offPreset = 2'd1;
  localparam logic [1:0] offCount  = 2'd2;
  localparam logic [1:0] offRsvd   = 2'd3;

  localparam logic [1:0] stIdle = 2'd0;
  localparam logic [1:0] stLoad = 2'd1;
  localparam logic [1:0] stCnt  = 2'd2;
  localparam logic [1:0] stInt  = 2'd3;

  localparam logic [1:0] modeOneShot = 2'b00;
  localparam logic [1:0] modeAuto    = 2'b01;

  localparam int ctrlEnBit   = 0;
  localparam int ctrlModeLsb = 1;
  localparam int ctrlModeMsb = 2;
  localparam int ctrlImBit   = 3;

  // Packed so that the field order matches the CTRL bit layout above.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tcCtrlT;

  function automatic logic [31:0] ctrlReadback(input tcCtrlT c);
    return {28'd0, c};
  endfunction

endpackage

// File: rtl/tc_timer.sv
// Memory-mapped down-counter timer with level interrupt.
// Optional auto-reload mode is built only when TC_AUTORELOAD_EN is defined.
module tc_timer
  import tc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [3:0]  ByteEn,
  output logic [31:0] RD,
  output logic        IRQ
);

  tcCtrlT      ctrlReg;
  logic [31:0] presetReg;
  logic [31:0] countReg;
  logic [31:0] countNext;
  logic [1:0]  stateReg;
  logic [1:0]  stateNext;
  logic        pendReg;
  logic        pendSet;
  logic        pendClr;
  logic        enClr;
  logic        reloadMode;

  logic        sel;
  logic        wrEn;
  logic        ctrlWr;
  logic        presetWr;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^Addr[1:0];

  assign sel      = (Addr[31:4] == BASE_ADDR[31:4]);
  assign wrEn     = sel && (ByteEn == 4'b1111);
  assign ctrlWr   = wrEn && (Addr[3:2] == offCtrl);
  assign presetWr = wrEn && (Addr[3:2] == offPreset);

`ifdef TC_AUTORELOAD_EN
  assign reloadMode = (ctrlReg.mode == modeAuto);
`else
  assign reloadMode = 1'b0;
`endif

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    pendSet   = 1'b0;
    pendClr   = 1'b0;
    enClr     = 1'b0;
    case (stateReg)
      stIdle: begin
        if (ctrlReg.en) stateNext = stLoad;
      end
      stLoad: begin
        countNext = presetReg;
        stateNext = stCnt;
      end
      stCnt: begin
        if (!ctrlReg.en) begin
          stateNext = stIdle;
        end else if (countReg <= 32'd1) begin
          countNext = 32'd0;
          stateNext = stInt;
          pendSet   = 1'b1;
        end else begin
          countNext = countReg - 32'd1;
        end
      end
      stInt: begin
        if (reloadMode) begin
          pendClr   = 1'b1;
          stateNext = stLoad;
        end else begin
          enClr     = 1'b1;
          stateNext = stIdle;
        end
      end
      default: stateNext = stIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrlReg   <= '0;
      presetReg <= '0;
      countReg  <= '0;
      stateReg  <= stIdle;
      pendReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      // A software CTRL write overrides the hardware one-shot EN clear.
      if (ctrlWr)     ctrlReg    <= WD[3:0];
      else if (enClr) ctrlReg.en <= 1'b0;
      if (presetWr) presetReg <= WD;
      // An expiry in the same cycle as a CTRL write keeps the interrupt.
      if (pendSet)                 pendReg <= 1'b1;
      else if (ctrlWr || pendClr)  pendReg <= 1'b0;
    end
  end

  always_comb begin
    RD = 32'd0;
    if (sel) begin
      case (Addr[3:2])
        offCtrl:   RD = ctrlReadback(ctrlReg);
        offPreset: RD = presetReg;
        offCount:  RD = countReg;
        default:   RD = 32'd0;
      endcase
    end
  end

  assign IRQ = pendReg & ctrlReg.im;

endmodule
